f_datapath: RTL and testbench



---
 rtl/f_datapath.sv | 129 ++++++++++++
 tb/tb_f_datapath.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/f_datapath.sv
// f_datapath -- slice-wise Keccak pi permutation unit.
//
// Reorders one 25-bit state slice at a time:
//   mem[5*y+x] = line[5*x + ((x+3y) mod 5)]
// The source column (x+3y) mod 5 is formed by accumulating j+3i and then
// subtracting 5 once per cycle until the result drops below 5.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start_i  in   level enable; new slices are accepted only while high
//   line_i   in   25-bit input slice, bit 5*y+x = A[x][y]
//   count_i  in   6-bit slice index tagging line_i
//   mem_o    out  permuted slice, bit 5*y+x = B[x][y]
//   done_o   out  one-cycle pulse when mem_o is updated
//   ok_o     out  high while mem_o holds the result for the latched index
module f_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [24:0] line_i,
  input  logic [5:0]  count_i,
  output logic [24:0] mem_o,
  output logic        done_o,
  output logic        ok_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CALC, REDUCE, WRITE, NEXT, DONE
  } state_t;

  state_t      state_q;
  logic [24:0] in_q;
  logic [24:0] res_q;
  logic [24:0] mem_q;
  logic [5:0]  last_q;
  logic        seen_q;    // at least one slice accepted since reset
  logic [2:0]  i_q;       // y
  logic [2:0]  j_q;       // x
  logic [4:0]  acc_q;
  logic        done_q;
  logic        ok_q;

  // j + 3i, at most 16
  logic [4:0] acc_d;
  assign acc_d = {2'b00, j_q} + {2'b00, i_q} + {1'b0, i_q, 1'b0};

  // Bit 5 of acc-5 is the sign: clear means acc >= 5, keep subtracting.
  logic [5:0] acc_sub;
  assign acc_sub = {1'b0, acc_q} - 6'd5;

  // Destination 5*i+j and source 5*j+acc; acc < 5 here so both stay <= 24.
  logic [4:0] wr_idx;
  logic [4:0] rd_idx;
  assign wr_idx = {i_q, 2'b00} + {2'b00, i_q} + {2'b00, j_q};
  assign rd_idx = {j_q, 2'b00} + {2'b00, j_q} + acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      res_q   <= '0;
      mem_q   <= '0;
      last_q  <= '0;
      seen_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && (!seen_q || count_i != last_q))
            state_q <= LOAD;
        end
        LOAD: begin
          in_q    <= line_i;
          last_q  <= count_i;
          seen_q  <= 1'b1;
          res_q   <= '0;
          i_q     <= '0;
          j_q     <= '0;
          ok_q    <= 1'b0;
          state_q <= CALC;
        end
        CALC: begin
          acc_q   <= acc_d;
          state_q <= REDUCE;
        end
        REDUCE: begin
          if (!acc_sub[5]) acc_q   <= acc_sub[4:0];
          else             state_q <= WRITE;
        end
        WRITE: begin
          res_q[wr_idx] <= in_q[rd_idx];
          state_q       <= NEXT;
        end
        NEXT: begin
          if (j_q == 3'd4) begin
            j_q <= '0;
            if (i_q == 3'd4) begin
              state_q <= DONE;
            end else begin
              i_q     <= i_q + 3'd1;
              state_q <= CALC;
            end
          end else begin
            j_q     <= j_q + 3'd1;
            state_q <= CALC;
          end
        end
        DONE: begin
          mem_q   <= res_q;
          done_q  <= 1'b1;
          ok_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_o  = mem_q;
  assign done_o = done_q;
  assign ok_o   = ok_q;

endmodule

// File: tb/tb_f_datapath.sv
// Self-checking bench for f_datapath: directed slices with literal
// expectations, an index sweep with wrap, hold/idle behaviour and a
// mid-slice reset, all against a formula-level reference permutation.
module tb_f_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [24:0] line_i;
  logic [5:0]  count_i;
  logic [24:0] mem_o;
  logic        done_o;
  logic        ok_o;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  logic [24:0] exp_line = '0;   // slice the block should be working on
  logic [24:0] exp_mem  = '0;   // what mem must hold between results

  f_datapath dut (
    .clk(clk), .rst(rst), .start_i(start_i), .line_i(line_i),
    .count_i(count_i), .mem_o(mem_o), .done_o(done_o), .ok_o(ok_o)
  );

  always #5 clk = ~clk;

  // Reference: B[x][y] = A[(x+3y) mod 5][x]
  function automatic logic [24:0] perm(input logic [24:0] a);
    logic [24:0] b;
    b = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        b[5*y+x] = a[5*x + ((x + 3*y) % 5)];
    return b;
  endfunction

  function automatic int popc(input logic [24:0] v);
    int c;
    c = 0;
    for (int k = 0; k < 25; k++) c += int'(v[k]);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model state.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("rst_mem", {7'd0, mem_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_ok", {31'd0, ok_o}, 32'd0);
        exp_mem = '0;
      end else if (done_o) begin
        done_cnt++;
        chk("done_mem", {7'd0, mem_o}, {7'd0, perm(exp_line)});
        chk("done_ok", {31'd0, ok_o}, 32'd1);
        chk("popcount", popc(mem_o), popc(exp_line));
        exp_mem = perm(exp_line);
      end else begin
        chk("hold_mem", {7'd0, mem_o}, {7'd0, exp_mem});
      end
    end
  end

  // Present a slice and wait for its result; checks latency, one pulse,
  // and the expected result.
  task automatic run(input string nm, input logic [24:0] l, input logic [5:0] c,
                     input logic [24:0] exp);
    int n;
    int d0;
    line_i   = l;
    count_i  = c;
    start_i  = 1'b1;
    exp_line = l;
    d0 = done_cnt;
    n  = 0;
    while (!done_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_seen"}, {31'd0, done_o}, 32'd1);
    chk({nm, "_lat_ok"}, {31'd0, (n <= 161)}, 32'd1);
    chk({nm, "_mem"}, {7'd0, mem_o}, {7'd0, exp});
    chk({nm, "_ok"}, {31'd0, ok_o}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_pulses"}, done_cnt - d0, 32'd1);
    chk({nm, "_done_low"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int d0;
    logic [24:0] r;
    rst = 1'b1; start_i = 1'b0; line_i = '0; count_i = '0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem", {7'd0, mem_o}, 32'd0);
    chk("reset_ok", {31'd0, ok_o}, 32'd0);

    line_i = 25'h0000001; count_i = 6'd0; start_i = 1'b1; exp_line = 25'h0000001;
    rst = 1'b0;
    run("bit0", 25'h0000001, 6'd0, 25'h0000001);
    run("a10", 25'h0000002, 6'd1, 25'h0000400);
    run("a01", 25'h0000020, 6'd2, 25'h0010000);
    run("ones", 25'h1FFFFFF, 6'd3, 25'h1FFFFFF);

    // Hold: constant index must not reprocess.
    d0 = done_cnt;
    repeat (500) @(posedge clk);
    #1;
    chk("hold_pulses", done_cnt - d0, 32'd0);
    chk("hold_ok", {31'd0, ok_o}, 32'd1);

    // start low in IDLE: a new index is ignored.
    start_i = 1'b0; count_i = 6'd9; line_i = 25'h0ABCDEF;
    repeat (300) @(posedge clk);
    #1;
    chk("idle_pulses", done_cnt - d0, 32'd0);
    chk("idle_mem", {7'd0, mem_o}, 32'h1FFFFFF);

    // Sweep 0..63 then wrap 63 -> 0.
    for (int k = 0; k < 64; k++) begin
      r = 25'($urandom);
      run("sweep", r, 6'(k), perm(r));
    end
    r = 25'h1234567;
    run("wrap", r, 6'd0, perm(r));

    // Mid-slice reset: outputs clear at once, slice redone afterwards.
    line_i = 25'h0000100; count_i = 6'd7; exp_line = 25'h0000100;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_mem", {7'd0, mem_o}, 32'd0);
    chk("midrst_ok", {31'd0, ok_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // A[3][1] (bit 8) lands at B[1][4] = bit 21
    run("after_rst", 25'h0000100, 6'd7, 25'h0200000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
